// File: rtl/alu.sv
// alu: RV32I execute-stage ALU with branch-condition flag and EX/MEM output register
//   clk         in   1   rising-edge clock
//   reset       in   1   synchronous active-high reset (clears registered outputs only)
//   SrcAE       in   32  operand A (rs1 or PC)
//   SrcBE       in   32  operand B (rs2 or immediate)
//   ALUControlE in   5   operation select
//   funct3E     in   3   branch compare select
//   ALUResultE  out  32  combinational result
//   Carry       out  1   combinational adder carry-out (ADD/SUB only)
//   ZeroE       out  1   combinational branch-taken flag
//   ALUResultQ  out  32  registered ALUResultE
//   CarryQ      out  1   registered Carry
//   ZeroQ       out  1   registered ZeroE
module alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [4:0]      ALUControlE,
    input  logic [2:0]      funct3E,
    output logic [XLEN-1:0] ALUResultE,
    output logic            Carry,
    output logic            ZeroE,
    output logic [XLEN-1:0] ALUResultQ,
    output logic            CarryQ,
    output logic            ZeroQ
);
    logic            w_sub;
    logic [XLEN-1:0] w_b;
    logic [XLEN:0]   w_sum;
    logic [4:0]      w_shamt;
    logic            w_slt;
    logic            w_sltu;
    logic [XLEN-1:0] w_sra;

    // One adder serves both ADD and SUB: A + ~B + 1 yields the no-borrow carry for SUB
    assign w_sub   = ALUControlE == 5'b00001;
    assign w_b     = w_sub ? ~SrcBE : SrcBE;
    assign w_sum   = {1'b0, SrcAE} + {1'b0, w_b} + {{XLEN{1'b0}}, w_sub};
    assign w_shamt = SrcBE[4:0];
    assign w_slt   = $signed(SrcAE) < $signed(SrcBE);
    assign w_sltu  = SrcAE < SrcBE;
    assign w_sra   = $signed(SrcAE) >>> w_shamt;
    assign Carry   = (ALUControlE == 5'b00000 || w_sub) ? w_sum[XLEN] : 1'b0;

    always_comb begin
        case (ALUControlE)
            5'b00000, 5'b00001: ALUResultE = w_sum[XLEN-1:0];
            5'b00010:           ALUResultE = SrcAE & SrcBE;
            5'b00011:           ALUResultE = SrcAE | SrcBE;
            5'b00100:           ALUResultE = SrcAE ^ SrcBE;
            5'b00101:           ALUResultE = {{(XLEN-1){1'b0}}, w_slt};
            5'b00110:           ALUResultE = {{(XLEN-1){1'b0}}, w_sltu};
            5'b00111:           ALUResultE = SrcAE << w_shamt;
            5'b01000:           ALUResultE = SrcAE >> w_shamt;
            5'b01001:           ALUResultE = w_sra;
            5'b01010:           ALUResultE = SrcBE;
            default:            ALUResultE = '0;
        endcase
    end

    // Branch flag is decoded from funct3 alone, independent of the ALU operation
    always_comb begin
        case (funct3E)
            3'b000:  ZeroE = SrcAE == SrcBE;
            3'b001:  ZeroE = SrcAE != SrcBE;
            3'b100:  ZeroE = w_slt;
            3'b101:  ZeroE = !w_slt;
            3'b110:  ZeroE = w_sltu;
            3'b111:  ZeroE = !w_sltu;
            default: ZeroE = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUResultQ <= '0;
            CarryQ     <= 1'b0;
            ZeroQ      <= 1'b0;
        end else begin
            ALUResultQ <= ALUResultE;
            CarryQ     <= Carry;
            ZeroQ      <= ZeroE;
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu; directed vectors with hand-computed results
module tb_alu;
    logic        clk;
    logic        reset;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [4:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic [31:0] ALUResultE;
    logic        Carry;
    logic        ZeroE;
    logic [31:0] ALUResultQ;
    logic        CarryQ;
    logic        ZeroQ;

    alu dut (
        .clk(clk), .reset(reset), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .ALUControlE(ALUControlE), .funct3E(funct3E),
        .ALUResultE(ALUResultE), .Carry(Carry), .ZeroE(ZeroE),
        .ALUResultQ(ALUResultQ), .CarryQ(CarryQ), .ZeroQ(ZeroQ)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] res;
        logic        c;
        logic        z;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string what, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s %s: got %h expected %h", name, what, got, want);
        end
    endtask

    // Monitor: inputs are held from the previous negedge, so just after the edge the
    // combinational outputs still reflect the vector and the Q outputs have captured it
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "result", ALUResultE, e.res);
            chk(e.name, "carry", {31'b0, Carry}, {31'b0, e.c});
            chk(e.name, "zero", {31'b0, ZeroE}, {31'b0, e.z});
            chk(e.name, "resultQ", ALUResultQ, e.rst ? 32'h0 : e.res);
            chk(e.name, "carryQ", {31'b0, CarryQ}, {31'b0, e.rst ? 1'b0 : e.c});
            chk(e.name, "zeroQ", {31'b0, ZeroQ}, {31'b0, e.rst ? 1'b0 : e.z});
        end
    end

    task automatic vec(input string name, input logic rst, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ctl, input logic [2:0] f3,
                       input logic [31:0] er, input logic ec, input logic ez);
        exp_t e;
        @(negedge clk);
        reset = rst;
        SrcAE = a;
        SrcBE = b;
        ALUControlE = ctl;
        funct3E = f3;
        e.name = name;
        e.rst = rst;
        e.res = er;
        e.c = ec;
        e.z = ez;
        q.push_back(e);
    endtask

    initial begin
        int n;
        reset = 1;
        SrcAE = 0;
        SrcBE = 0;
        ALUControlE = 0;
        funct3E = 0;
        vec("reset_add", 1, 32'd10, 32'd10, 5'b00000, 3'b000, 32'd20, 0, 1);
        vec("add_beq", 0, 32'd10, 32'd10, 5'b00000, 3'b000, 32'd20, 0, 1);
        vec("sub_eq_bne", 0, 32'd10, 32'd10, 5'b00001, 3'b001, 32'd0, 1, 0);
        vec("add_wrap_blt", 0, 32'hFFFFFFFF, 32'd1, 5'b00000, 3'b100, 32'd0, 1, 1);
        vec("slt_bltu", 0, 32'hFFFFFFFF, 32'd1, 5'b00101, 3'b110, 32'd1, 0, 0);
        vec("sltu_bgeu", 0, 32'hFFFFFFFF, 32'd1, 5'b00110, 3'b111, 32'd0, 0, 1);
        vec("add_ovf_bge", 0, 32'h7FFFFFFF, 32'd1, 5'b00000, 3'b101, 32'h80000000, 0, 1);
        vec("sra_4_f010", 0, 32'h80000000, 32'h24, 5'b01001, 3'b010, 32'hF8000000, 0, 0);
        vec("srl_4_f011", 0, 32'h80000000, 32'h24, 5'b01000, 3'b011, 32'h08000000, 0, 0);
        vec("sra_31_blt", 0, 32'h80000000, 32'd31, 5'b01001, 3'b100, 32'hFFFFFFFF, 0, 1);
        vec("sll_hib_bltu", 0, 32'd1, 32'hFFFFFFE3, 5'b00111, 3'b110, 32'd8, 0, 1);
        vec("and_bne", 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'b00010, 3'b001, 32'hF000F000, 0, 1);
        vec("or_beq", 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'b00011, 3'b000, 32'hFFF0FFF0, 0, 0);
        vec("xor_bgeu", 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'b00100, 3'b111, 32'h0FF00FF0, 0, 0);
        vec("passb_bge", 0, 32'h12345678, 32'hABCDE000, 5'b01010, 3'b101, 32'hABCDE000, 0, 1);
        vec("illegal_0b", 0, 32'h12345678, 32'hABCDE000, 5'b01011, 3'b011, 32'd0, 0, 0);
        vec("illegal_1f", 0, 32'h12345678, 32'hABCDE000, 5'b11111, 3'b001, 32'd0, 0, 1);
        vec("sub_borrow", 0, 32'd3, 32'd5, 5'b00001, 3'b110, 32'hFFFFFFFE, 0, 1);
        vec("add_3_5_bne", 0, 32'd3, 32'd5, 5'b00000, 3'b001, 32'd8, 0, 1);
        vec("reset_prio", 1, 32'd5, 32'd3, 5'b00001, 3'b000, 32'd2, 1, 0);
        vec("sub_5_3", 0, 32'd5, 32'd3, 5'b00001, 3'b000, 32'd2, 1, 0);
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
